mbus_busy_clr_sched: RTL

Always-on scheduler that shares the bus busy-clear resource between several requesters, such as the sleep controller, the bus controller and the wakeup logic. It grants one requester at a time in round-robin order and drives a fixed-width clear-busy pulse into the always-on busy controller. It then confirms that the bus idle flag BUS_BUSYn has returned high and acknowledges the requester, with a timeout and an isolation-aware abort. It lives in the always-on domain next to the busy controller and keeps sequencing while the bus-controller domain is isolated.

---
 rtl/mbus_busy_clr_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mbus_busy_clr_sched.sv
// Round-robin scheduler for the always-on busy-clear resource: grants one requester,
// drives a fixed-width CLR_BUSY pulse, confirms BUS_BUSYn and acknowledges, with timeout and isolation abort.
module mbus_busy_clr_sched #(
  parameter int N_REQ     = 3,
  parameter int PULSE_LEN = 2,
  parameter int TIMEOUT   = 15,
  parameter int HOLDOFF   = 1
) (
  input  logic             CLK,
  input  logic             RESET_BUSY,
  input  logic [N_REQ-1:0] REQ,
  input  logic [N_REQ-1:0] ISO_MASK,
  input  logic             BC_RELEASE_ISO,
  input  logic             BUS_BUSYn,
  output logic [N_REQ-1:0] GNT,
  output logic             CLR_BUSY,
  output logic [N_REQ-1:0] ACK,
  output logic             ERR
);

  localparam int MAX_PT  = (PULSE_LEN > TIMEOUT) ? PULSE_LEN : TIMEOUT;
  localparam int CNT_MAX = (MAX_PT > HOLDOFF) ? MAX_PT : HOLDOFF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int LW      = $clog2(N_REQ);

  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] TO_LD    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HO_LD    = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_CONFIRM,
    S_HOLDOFF
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             clr_q, clr_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] elig;
  logic             pick_valid;
  logic [LW-1:0]    pick_idx;
  int               cand;
  logic             abort;
  logic             op_done;

  assign elig  = REQ & ~(ISO_MASK & {N_REQ{BC_RELEASE_ISO}});
  // Isolation re-asserted on the granted requester's domain kills the pulse.
  assign abort = BC_RELEASE_ISO & |(gnt_q & ISO_MASK);

  // Round-robin pick: first eligible index scanning upward from last+1.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_q) + i) % N_REQ;
      if (!pick_valid && elig[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = LW'(cand);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    clr_d   = clr_q;
    ack_d   = '0;
    err_d   = 1'b0;
    op_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          clr_d           = 1'b1;
          cnt_d           = PULSE_LD;
          last_d          = pick_idx;
          state_d         = S_PULSE;
        end
      end
      S_PULSE: begin
        if (abort) begin
          clr_d   = 1'b0;
          err_d   = 1'b1;
          op_done = 1'b1;
        end else if (cnt_q == '0) begin
          clr_d   = 1'b0;
          cnt_d   = TO_LD;
          state_d = S_CONFIRM;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CONFIRM: begin
        if (BUS_BUSYn) begin
          ack_d   = gnt_q;
          op_done = 1'b1;
        end else if (cnt_q == '0) begin
          ack_d   = gnt_q;
          err_d   = 1'b1;
          op_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Grant drops on the same edge that finishes the operation.
    if (op_done) begin
      gnt_d = '0;
      if (HOLDOFF == 0) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = S_HOLDOFF;
        cnt_d   = HO_LD;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_BUSY) begin
    if (!RESET_BUSY) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= LW'(N_REQ - 1);
      gnt_q   <= '0;
      clr_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      clr_q   <= clr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign GNT      = gnt_q;
  assign CLR_BUSY = clr_q;
  assign ACK      = ack_q;
  assign ERR      = err_q;

endmodule
